// File: rtl/symbol_serializer_10b.sv
// Symbol serializer: buffers 10-bit 8b/10b symbols in a small FIFO and shifts
// them out LSB first, one bit per clk. When the FIFO is empty at a symbol
// boundary, a K28.5 comma of the polarity selected by the running disparity
// is inserted so the line stays DC balanced.
//
// Handshake: a symbol is transferred on the rising clk edge where both
// symbol_valid_i and symbol_ready_o are high. symbol_ready_o is a register
// (no combinational path from symbol_valid_i), low in reset, and high
// whenever the FIFO has at least one free entry. Upstream may hold
// symbol_valid_i and symbol_i until it sees the transfer.
module symbol_serializer_10b #(
    parameter int         FIFO_DEPTH = 4,
    parameter logic [9:0] IDLE_RDN   = 10'b0101111100,
    parameter logic [9:0] IDLE_RDP   = 10'b1010000011
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [9:0]                    symbol_i,
    input  logic                          symbol_valid_i,
    output logic                          symbol_ready_o,
    output logic                          serial_o,
    output logic                          symbol_start_o,
    output logic                          idle_o,
    output logic                          rd_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);

    logic [9:0]    mem [0:FIFO_DEPTH-1];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] level_next;
    logic [3:0]    bit_cnt;
    logic [8:0]    shreg;

    logic          boundary;
    logic          push;
    logic          pop;
    logic [9:0]    load_sym;
    logic [3:0]    load_ones;

    function automatic logic [3:0] count_ones(input logic [9:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 10; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

    // Boundary, transfer and next-symbol selection; pop uses the level before any same-edge push.
    always_comb begin
        boundary  = (bit_cnt == 4'd9);
        push      = symbol_valid_i && symbol_ready_o;
        pop       = boundary && (fifo_level_o != '0);
        load_sym  = rd_o ? IDLE_RDP : IDLE_RDN;
        if (pop) begin
            load_sym = mem[rd_ptr];
        end
        load_ones = count_ones(load_sym);
        level_next = fifo_level_o;
        if (push && !pop) begin
            level_next = fifo_level_o + 1'b1;
        end else if (!push && pop) begin
            level_next = fifo_level_o - 1'b1;
        end
    end

    // FIFO storage; written only on an accepted transfer, contents need no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= symbol_i;
        end
    end

    // Pointers, level, ready, bit counter, shift register and running disparity.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            fifo_level_o   <= '0;
            symbol_ready_o <= 1'b0;
            bit_cnt        <= 4'd9;
            shreg          <= '0;
            serial_o       <= 1'b0;
            symbol_start_o <= 1'b0;
            idle_o         <= 1'b0;
            rd_o           <= 1'b0;
        end else begin
            fifo_level_o   <= level_next;
            symbol_ready_o <= (level_next < DEPTH_L);
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (boundary) begin
                bit_cnt        <= 4'd0;
                serial_o       <= load_sym[0];
                shreg          <= load_sym[9:1];
                symbol_start_o <= 1'b1;
                idle_o         <= !pop;
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                // Unbalanced codes other than 4/6 ones leave RD alone; the check flags them in simulation.
                assert (load_ones == 4'd4 || load_ones == 4'd5 || load_ones == 4'd6);
                if (load_ones == 4'd6) begin
                    rd_o <= 1'b1;
                end else if (load_ones == 4'd4) begin
                    rd_o <= 1'b0;
                end
            end else begin
                bit_cnt        <= bit_cnt + 4'd1;
                serial_o       <= shreg[0];
                shreg          <= {1'b0, shreg[8:1]};
                symbol_start_o <= 1'b0;
            end
        end
    end

endmodule
